// File: rtl/pim_pkg.sv
// ---------------------------------------------------------------------------
// pim_pkg
// Shared definitions for the PIM request arbiter slice: FSM state encoding,
// AXI4 constant field values and the PIM MAC trigger ID.
// No ports (package).
// ---------------------------------------------------------------------------
package pim_pkg;

    // Transaction FSM: one state per AXI channel phase plus a response pulse
    typedef enum logic [2:0] {
        IDLE,
        AW,
        W,
        B,
        AR,
        R,
        RESP
    } pim_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Writes with this ID trigger a MAC in the PIM slave; the arbiter treats
    // them as ordinary writes.
    localparam logic [7:0] PIM_MAC_ID = 8'h80;

endpackage

// File: rtl/pim_req_arbiter_if.sv
// ---------------------------------------------------------------------------
// pim_req_arbiter_if
// AXI4 master bus between pim_req_arbiter and the shared axi_pim slave.
// Only the fields a single-beat transaction needs are carried.
// Modports:
//   master - arbiter side (drives aw/w/ar channels, bready, rready)
//   slave  - PIM slave side (drives awready, wready, arready, b and r channels)
// ---------------------------------------------------------------------------
interface pim_req_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 8
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;

    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/pim_rr_arbiter.sv
// ---------------------------------------------------------------------------
// pim_rr_arbiter
// Two-way round-robin grant selection, purely combinational.
// Ports:
//   i_valid[1:0]   - pending requests
//   i_lastGrant    - index granted most recently
//   i_enable       - arbitration allowed this cycle
//   o_grant        - selected requester index
//   o_grantValid   - a grant is issued this cycle
// ---------------------------------------------------------------------------
module pim_rr_arbiter (
    input  logic [1:0] i_valid,
    input  logic       i_lastGrant,
    input  logic       i_enable,
    output logic       o_grant,
    output logic       o_grantValid
);

    // A lone requester always wins; on a tie the one not served last wins,
    // so two busy requesters strictly alternate.
    always_comb begin
        o_grant      = 1'b0;
        o_grantValid = 1'b0;
        if (i_valid == 2'b11) begin
            o_grant = ~i_lastGrant;
        end else begin
            o_grant = i_valid[1];
        end
        o_grantValid = i_enable && (i_valid != 2'b00);
    end

endmodule

// File: rtl/pim_req_arbiter.sv
// ---------------------------------------------------------------------------
// pim_req_arbiter
// Shares one AXI4 PIM slave between two single-word requesters. Requests are
// arbitrated round-robin and serialised into single-beat AXI4 transactions,
// one in flight at a time; the response pulses back on the granted side only.
// Ports:
//   clk, rst                        - clock, synchronous active-high reset
//   i_req_valid_N / o_req_ready_N   - request handshake, N = 0,1
//   i_req_write_N, i_req_id_N,
//   i_req_addr_N, i_req_wdata_N     - request payload
//   o_resp_valid_N, o_resp_rdata_N,
//   o_resp_err_N                    - one-cycle response, no backpressure
//   axi                             - AXI4 master bus (pim_req_arbiter_if)
// Optional macro PIM_ARB_STATS_EN adds o_grant_cnt_0, o_grant_cnt_1 (32-bit
// wrapping accept counters) and o_err_cnt (16-bit saturating error counter).
// ---------------------------------------------------------------------------
module pim_req_arbiter
    import pim_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req_valid_0,
    output logic                  o_req_ready_0,
    input  logic                  i_req_write_0,
    input  logic [ID_WIDTH-1:0]   i_req_id_0,
    input  logic [ADDR_WIDTH-1:0] i_req_addr_0,
    input  logic [DATA_WIDTH-1:0] i_req_wdata_0,
    output logic                  o_resp_valid_0,
    output logic [DATA_WIDTH-1:0] o_resp_rdata_0,
    output logic                  o_resp_err_0,
    input  logic                  i_req_valid_1,
    output logic                  o_req_ready_1,
    input  logic                  i_req_write_1,
    input  logic [ID_WIDTH-1:0]   i_req_id_1,
    input  logic [ADDR_WIDTH-1:0] i_req_addr_1,
    input  logic [DATA_WIDTH-1:0] i_req_wdata_1,
    output logic                  o_resp_valid_1,
    output logic [DATA_WIDTH-1:0] o_resp_rdata_1,
    output logic                  o_resp_err_1,
`ifdef PIM_ARB_STATS_EN
    output logic [31:0]           o_grant_cnt_0,
    output logic [31:0]           o_grant_cnt_1,
    output logic [15:0]           o_err_cnt,
`endif
    pim_req_arbiter_if.master     axi
);

    localparam logic [2:0] AXI_SIZE = 3'($clog2(STRB_WIDTH));

    pim_state_t                     r_state;
    logic                           r_lastGrant;
    logic                           r_grantIdx;
    logic [ID_WIDTH-1:0]            r_id;
    logic [ADDR_WIDTH-1:0]          r_addr;
    logic [DATA_WIDTH-1:0]          r_wdata;
    logic                           r_awvalid;
    logic                           r_wvalid;
    logic                           r_bready;
    logic                           r_arvalid;
    logic                           r_rready;
    logic [1:0]                     r_respValid;
    logic [1:0]                     r_respErr;
    logic [1:0][DATA_WIDTH-1:0]     r_respRdata;

    logic                           w_arbEnable;
    logic                           w_grant;
    logic                           w_grantValid;
    logic                           w_selWrite;
    logic [ID_WIDTH-1:0]            w_selId;
    logic [ADDR_WIDTH-1:0]          w_selAddr;
    logic [DATA_WIDTH-1:0]          w_selWdata;
    logic                           w_bErr;
    logic                           w_rErr;
    logic                           w_unusedRlast;

    // Arbitration only happens while idle and never during reset, which also
    // keeps both ready outputs low while rst is asserted.
    assign w_arbEnable = (r_state == IDLE) && !rst;

    pim_rr_arbiter u_rrArbiter (
        .i_valid      ({i_req_valid_1, i_req_valid_0}),
        .i_lastGrant  (r_lastGrant),
        .i_enable     (w_arbEnable),
        .o_grant      (w_grant),
        .o_grantValid (w_grantValid)
    );

    assign o_req_ready_0 = w_grantValid && !w_grant;
    assign o_req_ready_1 = w_grantValid &&  w_grant;

    assign w_selWrite = w_grant ? i_req_write_1 : i_req_write_0;
    assign w_selId    = w_grant ? i_req_id_1    : i_req_id_0;
    assign w_selAddr  = w_grant ? i_req_addr_1  : i_req_addr_0;
    assign w_selWdata = w_grant ? i_req_wdata_1 : i_req_wdata_0;

    // An ID mismatch is flagged like a slave error so a misrouted response
    // can never be mistaken for a good one.
    assign w_bErr = (axi.bresp != AXI_RESP_OKAY) || (axi.bid != r_id);
    assign w_rErr = (axi.rresp != AXI_RESP_OKAY) || (axi.rid != r_id);

    // arlen is always zero, so every read beat is the last one.
    assign w_unusedRlast = axi.rlast;

    assign axi.awid    = r_id;
    assign axi.awaddr  = r_addr;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = AXI_SIZE;
    assign axi.awburst = AXI_BURST_INCR;
    assign axi.awvalid = r_awvalid;
    assign axi.wdata   = r_wdata;
    assign axi.wstrb   = '1;
    assign axi.wlast   = r_wvalid;
    assign axi.wvalid  = r_wvalid;
    assign axi.bready  = r_bready;
    assign axi.arid    = r_id;
    assign axi.araddr  = r_addr;
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = AXI_SIZE;
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arvalid = r_arvalid;
    assign axi.rready  = r_rready;

    assign o_resp_valid_0 = r_respValid[0];
    assign o_resp_valid_1 = r_respValid[1];
    assign o_resp_err_0   = r_respErr[0];
    assign o_resp_err_1   = r_respErr[1];
    assign o_resp_rdata_0 = r_respRdata[0];
    assign o_resp_rdata_1 = r_respRdata[1];

    // Transaction FSM. Every AXI valid/ready and every response output is a
    // register set on entry to its state and cleared on the handshake, so AW
    // and W can never overlap. Response outputs are only non-zero during the
    // RESP pulse; a reset abandons the transaction without a response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_lastGrant <= 1'b1;
            r_grantIdx  <= 1'b0;
            r_id        <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_respValid <= '0;
            r_respErr   <= '0;
            r_respRdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grantValid) begin
                        r_grantIdx  <= w_grant;
                        r_lastGrant <= w_grant;
                        r_id        <= w_selId;
                        r_addr      <= w_selAddr;
                        r_wdata     <= w_selWdata;
                        if (w_selWrite) begin
                            r_awvalid <= 1'b1;
                            r_state   <= AW;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= AR;
                        end
                    end
                end
                AW: begin
                    if (axi.awready) begin
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b1;
                        r_state   <= W;
                    end
                end
                W: begin
                    if (axi.wready) begin
                        r_wvalid <= 1'b0;
                        r_bready <= 1'b1;
                        r_state  <= B;
                    end
                end
                B: begin
                    if (axi.bvalid) begin
                        r_bready                <= 1'b0;
                        r_respValid[r_grantIdx] <= 1'b1;
                        r_respErr[r_grantIdx]   <= w_bErr;
                        r_state                 <= RESP;
                    end
                end
                AR: begin
                    if (axi.arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= R;
                    end
                end
                R: begin
                    if (axi.rvalid) begin
                        r_rready                <= 1'b0;
                        r_respValid[r_grantIdx] <= 1'b1;
                        r_respErr[r_grantIdx]   <= w_rErr;
                        r_respRdata[r_grantIdx] <= axi.rdata;
                        r_state                 <= RESP;
                    end
                end
                RESP: begin
                    r_respValid <= '0;
                    r_respErr   <= '0;
                    r_respRdata <= '0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef PIM_ARB_STATS_EN
    logic [31:0] r_grantCnt0;
    logic [31:0] r_grantCnt1;
    logic [15:0] r_errCnt;
    logic        w_errEvent;

    assign w_errEvent = ((r_state == B) && axi.bvalid && w_bErr) ||
                        ((r_state == R) && axi.rvalid && w_rErr);

    // Accept counters wrap naturally; the error counter sticks at all-ones
    // so a long error burst is never reported as a small number.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grantCnt0 <= '0;
            r_grantCnt1 <= '0;
            r_errCnt    <= '0;
        end else begin
            if (o_req_ready_0 && i_req_valid_0) begin
                r_grantCnt0 <= r_grantCnt0 + 32'd1;
            end
            if (o_req_ready_1 && i_req_valid_1) begin
                r_grantCnt1 <= r_grantCnt1 + 32'd1;
            end
            if (w_errEvent && (r_errCnt != 16'hFFFF)) begin
                r_errCnt <= r_errCnt + 16'd1;
            end
        end
    end

    assign o_grant_cnt_0 = r_grantCnt0;
    assign o_grant_cnt_1 = r_grantCnt1;
    assign o_err_cnt     = r_errCnt;
`endif

endmodule

// File: doc/pim_req_arbiter.md
# pim_req_arbiter

Shares one `axi_pim` AXI4 slave between two requesters, for example a CPU-side bridge and a DMA or MAC-command engine. Each requester issues simple single-word read or write requests. The block arbitrates between them round-robin and serialises each request into one single-beat AXI4 transaction. The response is returned only to the requester that was granted. Exactly one transaction is in flight at any time; the PIM MAC trigger (write with id 0x80) passes through as an ordinary write.

## Interface
Parameters:
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 16, byte address width.
- STRB_WIDTH, DATA_WIDTH/8, write strobe width.
- ID_WIDTH, 8, AXI ID width.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid_N  in  1  request N (N=0,1) pending.
- req_ready_N  out  1  request N accepted this cycle.
- req_write_N  in  1  1=write, 0=read.
- req_id_N  in  ID_WIDTH  ID driven on awid/arid.
- req_addr_N  in  ADDR_WIDTH  byte address.
- req_wdata_N  in  DATA_WIDTH  write data.
- resp_valid_N  out  1  one-cycle response pulse; no backpressure.
- resp_rdata_N  out  DATA_WIDTH  read data; 0 for writes.
- resp_err_N  out  1  response error flag.
- m_axi_aw*: awid, awaddr, awlen(8), awsize(3), awburst(2), awvalid out; awready in.
- m_axi_w*: wdata, wstrb, wlast, wvalid out; wready in.
- m_axi_b*: bid, bresp(2), bvalid in; bready out.
- m_axi_ar*: arid, araddr, arlen(8), arsize(3), arburst(2), arvalid out; arready in.
- m_axi_r*: rid, rdata, rresp(2), rlast, rvalid in; rready out.

## Operation
- FSM states: IDLE, AW, W, B, AR, R, RESP.
- IDLE arbitration:
  - Grant goes to the single valid requester.
  - If both are valid, grant goes to the requester not in last_grant.
  - req_ready_N is combinational: (state==IDLE) && grant==N && !rst.
- On the accept handshake:
  - Capture write flag, id, address, data and grant index.
  - Update last_grant.
  - Go to AW for a write, AR for a read.
- AW: awvalid=1 until awready. Fixed fields: awlen=0, awsize=$clog2(STRB_WIDTH), awburst=INCR (2'b01). Then go to W.
- W: wvalid=1, wlast=1, wstrb all ones, until wready. Then go to B.
- B: bready=1 until bvalid. Capture bresp and bid. Then go to RESP.
- AR/R follow the same pattern: arvalid until arready; then rready=1 until rvalid; capture rdata, rresp, rid. rlast is ignored because arlen is 0.
- RESP:
  - resp_valid_N pulses for exactly one cycle on the granted index only.
  - resp_err = (resp != OKAY) || (returned id != captured id).
  - Then return to IDLE.
- AW and W are never asserted together. Neither arbitration nor request capture happens outside IDLE.
- Requester inputs may change freely after accept.

## Timing
- Reset values:
  - state=IDLE, last_grant=1, so requester 0 wins the first tie.
  - All m_axi valid/ready outputs 0.
  - req_ready_N, resp_valid_N, resp_err_N 0; resp_rdata_N 0.
  - Address, data and id outputs 0.
- Latency with an always-ready slave (accept = cycle 0): AW handshake cycle 1, W cycle 2, B cycle 3, resp_valid cycle 4, IDLE cycle 5.
  - Minimum throughput: one transaction per 5 cycles.
  - Reads have the same latency: AR cycle 1, R cycle 2, resp_valid cycle 3, IDLE cycle 4.
- Each slave stall extends the corresponding state by one cycle per stall cycle. There is no timeout.
- A request that becomes valid during RESP is seen in the following IDLE cycle.
- Reset mid-operation:
  - All outputs return to reset values on the next edge.
  - The in-flight transaction is abandoned and no response is issued.
  - The slave must share rst.
- Back-to-back from one requester, with the other idle: granted every time.

## Configuration
- PIM_ARB_STATS_EN defined:
  - Adds outputs grant_cnt_0 and grant_cnt_1, each 32-bit.
  - Each counts accepted requests; reset 0; wraps at 2^32.
  - Adds err_cnt, 16-bit, which increments on each resp_err and saturates at 0xFFFF.
- Not defined: the ports and counters do not exist; all other behaviour is identical.

## Structure
- Package pim_pkg holds:
  - the state enum;
  - AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00;
  - PIM_MAC_ID=8'h80.
- Sub-module pim_rr_arbiter: 2-way round-robin. Inputs: valid[1:0], last_grant, enable. Outputs: grant index, grant_valid. Purely combinational, used in IDLE only.

## Test plan
- Single write: req0 write addr 0x0010, data 0xDEADBEEF, id 0x01, slave always ready -> AW at cycle 1 with awlen=0, awsize=2, awburst=1; W at cycle 2 with wlast=1, wstrb=0xF; resp_valid_0 at cycle 4 with err=0; resp_valid_1 stays 0.
- Read-back: req1 read of 0x0010 after the previous write -> resp_valid_1 with rdata=0xDEADBEEF; req0 receives no response.
- Contention:
  - req0 and req1 held valid continuously for 6 transactions -> grants alternate 0,1,0,1,0,1, starting with 0.
  - With PIM_ARB_STATS_EN: grant_cnt_0 = grant_cnt_1 = 3.
- Backpressure: awready held low 3 cycles and bvalid delayed 4 cycles -> awvalid stays high with stable fields until the handshake; response arrives 7 cycles later than nominal.
- Error: slave returns bresp=2'b10, or bid≠0x80 for a MAC write with id 0x80 -> resp_err=1.
- Reset mid-transaction: rst asserted during W -> next cycle all valids are 0, no resp_valid, last_grant=1; a new request after reset completes normally.
